// File: rtl/lau_pkg.sv
// Shared types for the end-around-carry adder family: prefix speed selection,
// EAC operation codes and an index-width helper.
package lau_pkg;

    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;

    typedef enum logic {
        EAC_ADD = 1'b0,
        EAC_SUB = 1'b1
    } eac_op_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/eac_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after
// the pointer (cyclic); the pointer moves past the winner only on advance.
module eac_rr_arbiter
    import lau_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumReq-1:0] valid,
    input  logic              advance,
    output logic [NumReq-1:0] grant,
    output logic [IdxW-1:0]   grant_idx
);

    logic [IdxW-1:0] ptr_q;
    logic            found_s;
    logic            hit_s;
    int              idx_s;

    // Cyclic priority search starting at the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        idx_s     = 0;
        for (int off = 0; off < int'(NumReq); off++) begin
            idx_s        = (int'(ptr_q) + off) % int'(NumReq);
            hit_s        = !found_s && valid[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? IdxW'(idx_s) : grant_idx;
            found_s      = found_s | hit_s;
        end
    end

    // Pointer register: next search starts just after the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == IdxW'(NumReq - 32'd1)) ? '0 : grant_idx + IdxW'(1);
        end
    end

endmodule

// File: rtl/eac_adder_arbiter.sv
// One shared end-around-carry adder serving NumReq requesters with a two-stage
// pipeline. Define ELAU_EAC_ZERO_NORM_EN to map an all-ones result to zero.
module eac_adder_arbiter
    import lau_pkg::*;
#(
    parameter  int unsigned width  = 16,
    parameter  int unsigned NumReq = 4,
    parameter  speed_e      speed  = FAST,
    localparam int unsigned IdW    = idx_width(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq*width-1:0] req_a_i,
    input  logic [NumReq*width-1:0] req_b_i,
    input  logic [NumReq-1:0]       req_sub_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [width-1:0]        res_sum_o,
    output logic [IdW-1:0]          res_id_o,
    output logic                    res_co_o
);

    typedef struct packed {
        logic [width-1:0] a;
        logic [width-1:0] b;
        logic [IdW-1:0]   id;
    } stage_t;

    logic [NumReq-1:0] grant_s;
    logic [IdW-1:0]    grant_idx_s;
    logic              ready_en_q;
    logic              s0_valid_q;
    stage_t            s0_q;
    logic              s0_ready_s;
    logic              s1_ready_s;
    logic              advance_s;
    eac_op_e           op_s;
    logic [width-1:0]  a_sel_s;
    logic [width-1:0]  b_sel_s;
    logic [width-1:0]  g_s, p_s, gp_s, pp_s, go_s, sum_s, sum_out_s;
    logic              co_s;

    eac_rr_arbiter #(.NumReq(NumReq)) u_arb (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .valid     (req_valid_i),
        .advance   (advance_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Handshake control and operand selection for the granted requester.
    always_comb begin
        s1_ready_s  = !res_valid_o | res_ready_i;
        s0_ready_s  = !s0_valid_q | s1_ready_s;
        advance_s   = ready_en_q & s0_ready_s & (|grant_s);
        req_ready_o = grant_s & {NumReq{ready_en_q & s0_ready_s}};
        a_sel_s     = req_a_i[grant_idx_s*width +: width];
        op_s        = req_sub_i[grant_idx_s] ? EAC_SUB : EAC_ADD;
        b_sel_s     = (op_s == EAC_SUB) ? ~req_b_i[grant_idx_s*width +: width]
                                        : req_b_i[grant_idx_s*width +: width];
    end

    // End-around prefix adder: carry-in is the group carry-out of the word.
    always_comb begin
        g_s  = s0_q.a & s0_q.b;
        p_s  = s0_q.a ^ s0_q.b;
        gp_s = g_s;
        pp_s = p_s;
        if (speed == FAST) begin
            for (int d = 1; d < int'(width); d = d * 2) begin
                for (int i = int'(width) - 1; i >= d; i--) begin
                    gp_s[i] = gp_s[i] | (pp_s[i] & gp_s[i-d]);
                    pp_s[i] = pp_s[i] & pp_s[i-d];
                end
            end
        end else begin
            for (int i = 1; i < int'(width); i++) begin
                gp_s[i] = gp_s[i] | (pp_s[i] & gp_s[i-1]);
                pp_s[i] = pp_s[i] & pp_s[i-1];
            end
        end
        co_s  = gp_s[width-1];
        // go_s[width-1] collapses to co_s and feeds the diagnostic carry output.
        go_s  = gp_s | (pp_s & {width{co_s}});
        sum_s = p_s ^ {go_s[width-2:0], co_s};
`ifdef ELAU_EAC_ZERO_NORM_EN
        sum_out_s = (&sum_s) ? '0 : sum_s;
`else
        sum_out_s = sum_s;
`endif
    end

    // Ready is withheld until the first clock after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Stage 0: capture the granted operands with B already conditioned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_valid_q <= 1'b0;
            s0_q       <= '0;
        end else if (s0_ready_s) begin
            s0_valid_q <= advance_s;
            if (advance_s) begin
                s0_q <= '{a: a_sel_s, b: b_sel_s, id: grant_idx_s};
            end
        end
    end

    // Stage 1: registered result, held while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_o <= 1'b0;
            res_sum_o   <= '0;
            res_id_o    <= '0;
            res_co_o    <= 1'b0;
        end else if (s1_ready_s) begin
            res_valid_o <= s0_valid_q;
            if (s0_valid_q) begin
                res_sum_o <= sum_out_s;
                res_id_o  <= s0_q.id;
                res_co_o  <= go_s[width-1];
            end
        end
    end

endmodule

// File: doc/eac_adder_arbiter.md
Name: eac_adder_arbiter

Overview:
- Shares one end-around-carry (ones' complement, modulo 2^W−1) adder datapath among NumReq requesters.
- Round-robin arbitration, valid/ready handshakes, two-stage pipeline, tagged results.
- Sits between ELAU's checksum/residue clients and the fast-carry-in end-around prefix adder. Lets one adder instance serve several independent streams.

Parameters:
- width, 16, operand/result word width (≥2)
- NumReq, 4, number of requesters (≥1)
- speed, lau_pkg::FAST, prefix structure speed, forwarded to the adder

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  per-requester operand valid
- req_ready_o  out  NumReq  per-requester accept; at most one bit high per cycle
- req_a_i  in  NumReq*width  operand A per requester (packed, requester 0 in LSBs)
- req_b_i  in  NumReq*width  operand B per requester
- req_sub_i  in  NumReq  1 = compute A − B (A + ~B), 0 = A + B
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumer ready
- res_sum_o  out  width  ones' complement sum
- res_id_o  out  $clog2(NumReq) (min 1)  index of originating requester
- res_co_o  out  1  raw carry-out before end-around wrap (diagnostic)

Behaviour:
- Reset: asynchronous on rst_ni low. All valid flags 0, rr pointer 0, data/id registers 0; res_valid_o=0, res_sum_o=0, res_id_o=0, res_co_o=0; req_ready_o=0 while in reset.
- Stage 0 (arbitrate/capture): grant = first valid requester at or after rr pointer, cyclic.
  - req_ready_o[g] = grant[g] & s0_ready, where s0_ready = !s0_valid_q | s1_ready.
  - On handshake, capture A, B' = sub ? ~B : B, and id into stage-0 regs; rr pointer <= g+1 mod NumReq.
  - Pointer is unchanged when no handshake occurs.
- Stage 1 (compute/output): G=A&B', P=A^B', end-around prefix with CI=CO, S=P^{GO[width-2:0],CO}; result registered into output regs.
  - s1_ready = !res_valid_o | res_ready_i.
- Latency: 2 cycles from request handshake to res_valid_o. Throughput: 1 result/cycle with res_ready_i held high.
- Backpressure: when res_ready_i is low, both stages hold and no data is lost. At most 2 requests are in flight.
- Ready/valid rules:
  - req_ready_o never depends on res_ready_i combinationally beyond s1_ready.
  - res_* outputs are stable while res_valid_o & !res_ready_i.
- Arithmetic: result ≡ A ± B mod (2^width − 1). The all-ones pattern (negative zero) is a legal output unless the optional feature is enabled.
- Requester withdrawal: a requester dropping valid without handshake is permitted; arbitration simply re-evaluates.
- Simultaneous capture and drain in one cycle: both stages advance, with no bubble.
- NumReq=1: arbiter degenerates to pass-through and res_id_o is constant 0.
- Reset mid-operation discards in-flight items without emitting them.

Optional Feature:
- Macro: ELAU_EAC_ZERO_NORM_EN
- Defined: a stage-1 result of all ones is replaced by all zeros (negative zero normalised). res_co_o is unaffected.
- Undefined: raw end-around result is output, all ones included.

Decomposition:
- lau_pkg additions: eac_op_e (EAC_ADD, EAC_SUB); a stage payload struct template (a, b, id) expressed as a typedef in the module, since it depends on parameters.
- Reuse lau_pkg::speed_e.
- Sub-module eac_rr_arbiter (NumReq): valid vector in, one-hot grant out, pointer update on advance. The EAC datapath instantiates the existing end-around prefix block.

Test Plan:
- width=8, single req0: A=0xF0, B=0x20, add -> res_sum=0x11, res_co=1, id=0, 2 cycles after handshake.
- Subtract: A=0x05, B=0x03 -> 0x02. A=0x03, B=0x03 -> 0xFF without the macro, 0x00 with ELAU_EAC_ZERO_NORM_EN.
- Fairness, NumReq=4: all requesters valid continuously for 8 cycles -> grant/res_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
- Backpressure: stream from req2, res_ready_i low 3 cycles -> exactly 2 accepted, outputs stable, then in-order drain with no loss or duplication.
- Sparse requests: only req1 and req3 valid, pointer at 2 -> grants 3,1,3,1.
- Reset mid-op: assert rst_ni low with 2 items in flight -> res_valid_o=0 immediately (asynchronous); after release no stale results emerge and the pointer is 0.
